// File: rtl/spm_config_arbiter_if.sv
// rtl/spm_config_arbiter_if.sv - requester, monitor and config-bus signals of the config arbiter
// slave is the arbiter side; master is the requester/monitor side.
interface spm_config_arbiter_if #(
  parameter int CFG_WIDTH = 512
);
  logic                 req0;
  logic                 req1;
  logic                 req2;
  logic [31:0]          addr0;
  logic [31:0]          addr1;
  logic [31:0]          addr2;
  logic [CFG_WIDTH-1:0] data0;
  logic [CFG_WIDTH-1:0] data1;
  logic [CFG_WIDTH-1:0] data2;
  logic                 settle0;
  logic                 settle1;
  logic                 settle2;
  logic [31:0]          x0mon;
  logic [31:0]          y0mon;
  logic [31:0]          z0mon;
  logic [31:0]          settle_timeout;
  logic [31:0]          config_addr;
  logic [CFG_WIDTH-1:0] config_data;
  logic [2:0]           done;
  logic                 timeout;
  logic                 busy;
  logic [1:0]           grant_id;

  modport slave (
    input  req0, req1, req2,
    input  addr0, addr1, addr2,
    input  data0, data1, data2,
    input  settle0, settle1, settle2,
    input  x0mon, y0mon, z0mon,
    input  settle_timeout,
    output config_addr, config_data, done, timeout, busy, grant_id
  );

  modport master (
    output req0, req1, req2,
    output addr0, addr1, addr2,
    output data0, data1, data2,
    output settle0, settle1, settle2,
    output x0mon, y0mon, z0mon,
    output settle_timeout,
    input  config_addr, config_data, done, timeout, busy, grant_id
  );
endinterface

// File: rtl/spm_config_arbiter.sv
// rtl/spm_config_arbiter.sv - three-way round-robin config write arbiter with monitor settle-wait
// One write per grant: IDLE -> ISSUE -> (SETTLE) -> DONE, one-cycle done pulse per requester.
module spm_config_arbiter #(
  parameter logic [31:0] IDLE_ADDR = 32'd0,
  parameter logic [31:0] XYZU_ADDR = 32'd1100,
  parameter int          CFG_WIDTH = 512
) (
  input logic                 a_clk,
  input logic                 a_resetn,
  spm_config_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [31:0]          r_config_addr;
  logic [CFG_WIDTH-1:0] r_config_data;
  logic [2:0]           r_done;
  logic                 r_timeout;
  logic                 r_busy;
  logic [1:0]           r_grant_id;
  logic [1:0]           r_rr_ptr;
  logic                 r_settle_qual;
  logic [31:0]          r_settle_cnt;

  logic [2:0]           w_req;
  logic                 w_grant;
  logic [1:0]           w_win;
  logic [1:0]           w_win_next;
  logic [31:0]          w_win_addr;
  logic [CFG_WIDTH-1:0] w_win_data;
  logic                 w_win_settle;
  logic                 w_match;
  logic                 w_expired;
  logic [2:0]           w_done_vec;

  assign w_req      = {bus.req2, bus.req1, bus.req0};
  assign w_grant    = |w_req;
  assign w_win_next = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
  assign w_done_vec = 3'b001 << r_grant_id;

  // Scan starts at the requester just after the previous winner.
  always_comb begin
    w_win = 2'd0;
    case (r_rr_ptr)
      2'd1:    w_win = w_req[1] ? 2'd1 : (w_req[2] ? 2'd2 : 2'd0);
      2'd2:    w_win = w_req[2] ? 2'd2 : (w_req[0] ? 2'd0 : 2'd1);
      default: w_win = w_req[0] ? 2'd0 : (w_req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_win_addr   = bus.addr0;
    w_win_data   = bus.data0;
    w_win_settle = bus.settle0;
    case (w_win)
      2'd1: begin
        w_win_addr   = bus.addr1;
        w_win_data   = bus.data1;
        w_win_settle = bus.settle1;
      end
      2'd2: begin
        w_win_addr   = bus.addr2;
        w_win_data   = bus.data2;
        w_win_settle = bus.settle2;
      end
      default: begin
        w_win_addr   = bus.addr0;
        w_win_data   = bus.data0;
        w_win_settle = bus.settle0;
      end
    endcase
  end

  // config_data still carries the latched payload, so it doubles as the settle target.
  assign w_match   = (bus.x0mon == r_config_data[31:0])  &&
                     (bus.y0mon == r_config_data[63:32]) &&
                     (bus.z0mon == r_config_data[95:64]);
  assign w_expired = (bus.settle_timeout != 32'd0) && (r_settle_cnt == bus.settle_timeout);

  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_next_state = ST_ISSUE;
      ST_ISSUE:  w_next_state = r_settle_qual ? ST_SETTLE : ST_DONE;
      ST_SETTLE: if (w_match || w_expired) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      r_config_addr <= IDLE_ADDR;
      r_config_data <= '0;
      r_done        <= 3'b000;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
      r_grant_id    <= 2'd0;
      r_rr_ptr      <= 2'd0;
      r_settle_qual <= 1'b0;
      r_settle_cnt  <= 32'd0;
    end else begin
      r_done    <= 3'b000;
      r_timeout <= 1'b0;
      r_busy    <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_grant_id    <= w_win;
            r_rr_ptr      <= w_win_next;
            r_config_addr <= w_win_addr;
            r_config_data <= w_win_data;
            r_settle_qual <= w_win_settle && (w_win_addr == XYZU_ADDR);
          end
        end
        ST_ISSUE: begin
          r_config_addr <= IDLE_ADDR;
          if (r_settle_qual) begin
            r_settle_cnt <= 32'd1;
          end else begin
            r_done <= w_done_vec;
          end
        end
        ST_SETTLE: begin
          if (w_match || w_expired) begin
            r_done    <= w_done_vec;
            r_timeout <= !w_match;
          end else begin
            r_settle_cnt <= r_settle_cnt + 32'd1;
          end
        end
        default: begin
          r_config_addr <= r_config_addr;
        end
      endcase
    end
  end

  assign bus.config_addr = r_config_addr;
  assign bus.config_data = r_config_data;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_spm_config_arbiter.sv
// tb/tb_spm_config_arbiter.sv - randomized self-checking bench for spm_config_arbiter
// A transaction-level model predicts each grant's issue, done and timeout cycles.
module tb_spm_config_arbiter;
  localparam int          CW     = 512;
  localparam logic [31:0] IDLE_A = 32'h0000_ABCD;
  localparam logic [31:0] XYZU_A = 32'd1100;
  localparam int          N_CYC  = 1900;
  localparam int          NEVER  = 32'h3FFF_FFFF;

  logic a_clk    = 1'b0;
  logic a_resetn = 1'b0;
  always #5 a_clk = ~a_clk;

  spm_config_arbiter_if #(.CFG_WIDTH(CW)) bus ();

  spm_config_arbiter #(
    .IDLE_ADDR (IDLE_A),
    .XYZU_ADDR (XYZU_A),
    .CFG_WIDTH (CW)
  ) dut (
    .a_clk    (a_clk),
    .a_resetn (a_resetn),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cur_x    = 0;

  logic          p_req    [3];
  logic [31:0]   p_addr   [3];
  logic [CW-1:0] p_data   [3];
  logic          p_settle [3];
  int            p_k      [3];
  int            p_t      [3];

  int            g_cyc, d_cyc, free_at, rr_ptr, match_cyc, rst_cyc;
  logic [1:0]    m_w;
  logic [31:0]   m_addr, m_tmo;
  logic [CW-1:0] m_data;
  logic          m_to, m_qual;
  logic          p6_rst_done;

  task automatic chk_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cur_x, obs, exp_v);
  endtask

  function automatic logic [CW-1:0] rand_data();
    logic [CW-1:0] v;
    for (int i = 0; i < CW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int phase_of(input int x);
    if (x < 12)   return 0;
    if (x < 40)   return 1;
    if (x < 140)  return 2;
    if (x < 220)  return 3;
    if (x < 280)  return 4;
    if (x < 1600) return 5;
    return 6;
  endfunction

  function automatic logic [2:0] mask_of(input int ph);
    case (ph)
      0:       return 3'b010;
      1, 5:    return 3'b111;
      6:       return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // k = settle cycle from which monitors match (0 = never), t = settle_timeout.
  task automatic raise(input int i, input int ph);
    p_req[i]  = 1'b1;
    p_data[i] = rand_data();
    case (ph)
      0: begin p_addr[i] = 32'd1101; p_settle[i] = 1'($urandom_range(0, 1)); p_k[i] = 1; p_t[i] = 0; end
      1: begin p_addr[i] = $urandom_range(0, 1) ? XYZU_A : $urandom; p_settle[i] = 1'b0; p_k[i] = 1; p_t[i] = 0; end
      2: begin p_addr[i] = XYZU_A; p_settle[i] = 1'b1; p_k[i] = 40; p_t[i] = 0;  end
      3: begin p_addr[i] = XYZU_A; p_settle[i] = 1'b1; p_k[i] = 0;  p_t[i] = 10; end
      4: begin p_addr[i] = XYZU_A; p_settle[i] = 1'b1; p_k[i] = 10; p_t[i] = 10; end
      6: begin p_addr[i] = XYZU_A; p_settle[i] = 1'b1; p_k[i] = 60; p_t[i] = 0;  end
      default: begin
        case ($urandom_range(0, 3))
          0, 1:    p_addr[i] = XYZU_A;
          2:       p_addr[i] = 32'd1101;
          default: p_addr[i] = $urandom;
        endcase
        p_settle[i] = ($urandom_range(0, 3) != 0);
        p_k[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30));
        case ($urandom_range(0, 2))
          0:       p_t[i] = 0;
          1:       p_t[i] = int'($urandom_range(1, 30));
          default: p_t[i] = p_k[i];
        endcase
        if (p_k[i] == 0 && p_t[i] == 0) p_t[i] = int'($urandom_range(1, 20));
      end
    endcase
  endtask

  task automatic apply_reset(input int x);
    g_cyc     = -100;
    d_cyc     = -100;
    m_w       = 2'd0;
    m_data    = '0;
    m_qual    = 1'b0;
    m_to      = 1'b0;
    rr_ptr    = 0;
    free_at   = x + 1;
    match_cyc = NEVER;
    rst_cyc   = x;
  endtask

  task automatic grant(input int x);
    int w = -1;
    int len;
    for (int k = 0; k < 3; k++) begin
      int idx = (rr_ptr + k) % 3;
      if (w < 0 && p_req[idx]) w = idx;
    end
    if (w < 0) return;
    m_w    = 2'(w);
    m_addr = p_addr[w];
    m_data = p_data[w];
    m_tmo  = 32'(p_t[w]);
    m_qual = p_settle[w] && (p_addr[w] == XYZU_A);
    g_cyc  = x;
    rr_ptr = (w + 1) % 3;
    if (!m_qual) begin
      d_cyc     = x + 2;
      m_to      = 1'b0;
      match_cyc = NEVER;
    end else begin
      if (p_k[w] != 0 && (p_t[w] == 0 || p_k[w] <= p_t[w])) begin
        len  = p_k[w];
        m_to = 1'b0;
      end else begin
        len  = p_t[w];
        m_to = 1'b1;
      end
      d_cyc     = x + 2 + len;
      match_cyc = (p_k[w] != 0) ? x + 1 + p_k[w] : NEVER;
    end
    free_at = d_cyc + 1;
  endtask

  task automatic drive_inputs(input int x);
    logic [95:0] mon;
    bus.req0 = p_req[0];  bus.addr0 = p_addr[0]; bus.data0 = p_data[0]; bus.settle0 = p_settle[0];
    bus.req1 = p_req[1];  bus.addr1 = p_addr[1]; bus.data1 = p_data[1]; bus.settle1 = p_settle[1];
    bus.req2 = p_req[2];  bus.addr2 = p_addr[2]; bus.data2 = p_data[2]; bus.settle2 = p_settle[2];
    bus.settle_timeout = m_tmo;
    mon = m_data[95:0];
    if (!(m_qual && x >= match_cyc)) mon[$urandom_range(0, 95)] ^= 1'b1;
    bus.x0mon = mon[31:0];
    bus.y0mon = mon[63:32];
    bus.z0mon = mon[95:64];
  endtask

  task automatic check_all(input int x);
    cur_x = x;
    chk_eq("config_addr", CW'(bus.config_addr), CW'((x == g_cyc + 1) ? m_addr : IDLE_A));
    chk_eq("config_data", bus.config_data, m_data);
    chk_eq("done",        CW'(bus.done),     CW'((x == d_cyc) ? (3'b001 << m_w) : 3'b000));
    chk_eq("timeout",     CW'(bus.timeout),  CW'((x == d_cyc) ? m_to : 1'b0));
    chk_eq("busy",        CW'(bus.busy),     CW'(x > g_cyc && x <= d_cyc));
    chk_eq("grant_id",    CW'(bus.grant_id), CW'(m_w));
  endtask

  initial begin
    int  ph;
    logic do_rst;
    for (int i = 0; i < 3; i++) begin
      p_req[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; p_settle[i] = 1'b0; p_k[i] = 0; p_t[i] = 0;
    end
    apply_reset(0);
    m_addr      = '0;
    m_tmo       = '0;
    p6_rst_done = 1'b0;
    drive_inputs(0);
    for (int x = 1; x <= N_CYC; x++) begin
      @(negedge a_clk);
      check_all(x);
      if (x == d_cyc) p_req[m_w] = 1'b0;
      if (!a_resetn) a_resetn = 1'b1;
      ph = phase_of(x);
      for (int i = 0; i < 3; i++) begin
        if (!p_req[i] && mask_of(ph)[i] && (ph != 5 || $urandom_range(0, 3) == 0)) raise(i, ph);
      end
      // The granted requester may change its inputs while the write is in flight.
      if (x > g_cyc && x < d_cyc && $urandom_range(0, 3) == 0) begin
        p_addr[m_w]   = $urandom;
        p_data[m_w]   = rand_data();
        p_settle[m_w] = ~p_settle[m_w];
      end
      do_rst = 1'b0;
      if (ph == 5 && x > rst_cyc + 1 && $urandom_range(0, 199) == 0) do_rst = 1'b1;
      if (ph == 6 && !p6_rst_done && m_qual && x == g_cyc + 12 && d_cyc > x + 1) begin
        do_rst      = 1'b1;
        p6_rst_done = 1'b1;
      end
      if (do_rst) begin
        a_resetn = 1'b0;
        apply_reset(x);
      end else if (x >= free_at) begin
        grant(x);
      end
      drive_inputs(x);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
